// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-port RAM agents.
// Holds the bank_select width rule that the read ports and the write-agent
// accounter must agree on, plus the read-port sizing constants.
package meduram_pkg;

  localparam int RDPORT_FIFO_DEPTH = 3;
  localparam int COLLISION_CNT_W   = 16;

  // The select carries a bank index followed by an optional collision flag in
  // the MSB. A single bank still takes one index bit so the port never
  // collapses to zero width.
  function automatic int select_width(input int nb_wragent, input int write_collision);
    return ((nb_wragent == 1) ? 1 : $clog2(nb_wragent)) + write_collision;
  endfunction

endpackage

// File: rtl/read_port_fifo.sv
// Response FIFO for read_port: 3 entries, in order, with a registered head.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   push, din     : write one entry at the end of the cycle
//   pop           : drop the head at the end of the cycle (ignored when empty)
//   count         : number of valid entries
//   head          : oldest entry, taken straight from a flop (zero after reset)
module read_port_fifo
  import meduram_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   push,
  input  logic                                   pop,
  input  logic [WIDTH-1:0]                       din,
  output logic [$clog2(RDPORT_FIFO_DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]                       head
);

  localparam int CNT_W = $clog2(RDPORT_FIFO_DEPTH + 1);

  logic [WIDTH-1:0] ent_q [RDPORT_FIFO_DEPTH];
  logic [WIDTH-1:0] ent_d [RDPORT_FIFO_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_ok, push_ok;

  // Shift-register organisation: entry 0 is always the head, so the head is
  // a plain flop and stays put while nothing is popped.
  always_comb begin
    ent_d   = ent_q;
    pop_ok  = pop && (count_q != '0);
    wr_idx  = count_q - CNT_W'(pop_ok);
    push_ok = push && (wr_idx < CNT_W'(RDPORT_FIFO_DEPTH));
    if (pop_ok) begin
      for (int i = 0; i < RDPORT_FIFO_DEPTH - 1; i++) begin
        ent_d[i] = ent_q[i+1];
      end
      ent_d[RDPORT_FIFO_DEPTH-1] = '0;
    end
    if (push_ok) begin
      ent_d[wr_idx] = din;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
      for (int i = 0; i < RDPORT_FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign count = count_q;
  assign head  = ent_q[0];

endmodule

// File: rtl/read_port.sv
// Read-agent front end of the multi-port RAM.
// Accepts read requests (valid/ready), strobes rden/rdaddr to the accounter
// and banks, registers the accounter's bank_select alongside the one-cycle
// bank read, picks the bank that last wrote the row and returns
// {collision, data} through a 3-entry response FIFO.
// Ports:
//   aclk, aresetn                          : clock, asynchronous active-low reset
//   req_valid, req_ready, req_addr         : request handshake
//   rden, rdaddr                           : read strobe/address to accounter and banks
//   bank_select                            : accounter answer for rdaddr (same cycle)
//   bank_rddata                            : all banks' read data, one cycle after rden
//   rsp_valid, rsp_ready                   : response handshake
//   rsp_data, rsp_collision                : response payload (FIFO head)
//   collision_count                        : saturating count of colliding responses
// Build option: READ_PORT_COLLISION_CNT_EN builds the collision counter;
// without it collision_count is tied to zero.
module read_port
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int NB_WRAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  output logic                         rden,
  output logic [ADDR_WIDTH-1:0]        rdaddr,
  input  logic [SELECT_WIDTH-1:0]      bank_select,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_collision,
  output logic [COLLISION_CNT_W-1:0]   collision_count
);

  localparam int IDX_W = SELECT_WIDTH - WRITE_COLLISION;
  localparam int CNT_W = $clog2(RDPORT_FIFO_DEPTH + 1);

  logic                    s1_valid_q, s1_valid_d;
  logic [SELECT_WIDTH-1:0] s1_sel_q, s1_sel_d;
  logic [IDX_W-1:0]        sel_idx;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_col;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_WIDTH:0]     fifo_head;
  logic [CNT_W:0]          credit_used;
  logic                    rsp_pop;

  // Credits count the FIFO plus the stage-1 entry still on its way in, so a
  // stage-1 push can never land on a full FIFO. Only flops feed this term.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
  assign req_ready   = aresetn && (credit_used < (CNT_W+1)'(RDPORT_FIFO_DEPTH));
  assign rden        = req_valid && req_ready;
  assign rdaddr      = req_addr;

  always_comb begin
    s1_valid_d = rden;
    s1_sel_d   = bank_select;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
    end
  end

  // Indices that name no bank (non-power-of-two bank counts) return zeros.
  always_comb begin
    sel_idx  = s1_sel_q[IDX_W-1:0];
    sel_data = '0;
    for (int k = 0; k < NB_WRAGENT; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_data = bank_rddata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_col = (WRITE_COLLISION == 1) ? s1_sel_q[SELECT_WIDTH-1] : 1'b0;
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  read_port_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (s1_valid_q),
    .pop     (rsp_pop),
    .din     ({sel_col, sel_data}),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  assign rsp_data      = fifo_head[DATA_WIDTH-1:0];
  assign rsp_collision = fifo_head[DATA_WIDTH];

`ifdef READ_PORT_COLLISION_CNT_EN
  logic [COLLISION_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (rsp_pop && rsp_collision && (coll_cnt_q != '1)) begin
      coll_cnt_d = coll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      coll_cnt_q <= '0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign collision_count = coll_cnt_q;
`else
  assign collision_count = '0;
`endif

endmodule

// File: tb/tb_read_port.sv
// Testbench for read_port. Two instances share all stimulus:
//   a: NB_WRAGENT=2, WRITE_COLLISION=1 (default build)
//   b: NB_WRAGENT=3, WRITE_COLLISION=0 (select 3 names no bank)
// The reference keeps a queue of accepted reads (select + bank data seen one
// cycle later) and derives expected responses from the bank/collision rules.
module tb_read_port;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic [1:0]  bank_select;
  logic        rsp_ready;
  logic [95:0] bank_rd;

  logic        req_ready_a, rden_a, rsp_valid_a, rsp_col_a;
  logic [7:0]  rdaddr_a;
  logic [31:0] rsp_data_a;
  logic [15:0] ccnt_a;
  logic        req_ready_b, rden_b, rsp_valid_b, rsp_col_b;
  logic [7:0]  rdaddr_b;
  logic [31:0] rsp_data_b;
  logic [15:0] ccnt_b;

  always #5 aclk = ~aclk;

  read_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_WRAGENT(2), .WRITE_COLLISION(1)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_addr(req_addr), .rden(rden_a), .rdaddr(rdaddr_a), .bank_select(bank_select),
    .bank_rddata(bank_rd[63:0]), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_a), .rsp_collision(rsp_col_a), .collision_count(ccnt_a)
  );

  read_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_WRAGENT(3), .WRITE_COLLISION(0)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_addr(req_addr), .rden(rden_b), .rdaddr(rdaddr_b), .bank_select(bank_select),
    .bank_rddata(bank_rd), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_b), .rsp_collision(rsp_col_b), .collision_count(ccnt_b)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [95:0] bank;
  } rd_t;

  rd_t        mq[$];
  bit         s1_pend;
  logic [1:0] s1_sel;
  int         exp_cnt;
  int         acc_cnt;
  int         n_checks;
  int         n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {collision, data} for a bank count / collision option from the raw select.
  function automatic logic [32:0] exp_rsp(input int nb, input int wc,
                                          input logic [1:0] sel, input logic [95:0] bank);
    int         iw;
    int         idx;
    logic       col;
    logic [31:0] d;
    iw  = (nb == 1) ? 1 : $clog2(nb);
    idx = int'(sel) % (1 << iw);
    col = (wc == 1) ? sel[iw] : 1'b0;
    d   = (idx < nb) ? bank[idx*32 +: 32] : 32'h0;
    return {col, d};
  endfunction

  function automatic logic [95:0] rnd_bank();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    s1_pend = 1'b0;
    s1_sel  = 2'b00;
    exp_cnt = 0;
  endtask

  task automatic check_outs(input logic exp_ready);
    logic [32:0] ea, eb;
    chk("req_ready_a", req_ready_a, exp_ready);
    chk("req_ready_b", req_ready_b, exp_ready);
    chk("rsp_valid_a", rsp_valid_a, mq.size() != 0);
    chk("rsp_valid_b", rsp_valid_b, mq.size() != 0);
    if (mq.size() != 0) begin
      ea = exp_rsp(2, 1, mq[0].sel, mq[0].bank);
      eb = exp_rsp(3, 0, mq[0].sel, mq[0].bank);
      chk("rsp_data_a", rsp_data_a, ea[31:0]);
      chk("rsp_col_a",  rsp_col_a,  ea[32]);
      chk("rsp_data_b", rsp_data_b, eb[31:0]);
      chk("rsp_col_b",  rsp_col_b,  eb[32]);
    end
`ifdef READ_PORT_COLLISION_CNT_EN
    chk("coll_cnt_a", ccnt_a, exp_cnt);
`else
    chk("coll_cnt_a", ccnt_a, 0);
`endif
    chk("coll_cnt_b", ccnt_b, 0);
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic cycle(input bit rv, input bit rr, input logic [1:0] sel,
                       input logic [7:0] addr, input logic [95:0] bank);
    logic  exp_ready;
    logic  acc;
    logic  pop;
    rd_t   e;
    req_valid   = rv;
    rsp_ready   = rr;
    bank_select = sel;
    req_addr    = addr;
    bank_rd     = bank;
    #1;
    exp_ready = aresetn && ((mq.size() + int'(s1_pend)) < 3);
    acc       = rv && exp_ready;
    check_outs(exp_ready);
    chk("rden_a", rden_a, acc);
    chk("rden_b", rden_b, acc);
    if (acc) chk("rdaddr_a", rdaddr_a, addr);
    if (rden_a) acc_cnt++;
    pop = (mq.size() != 0) && rr;
    if (pop) begin
      if (exp_rsp(2, 1, mq[0].sel, mq[0].bank) >> 32 != 0 && exp_cnt < 65535) exp_cnt++;
      void'(mq.pop_front());
    end
    if (s1_pend) begin
      e.sel  = s1_sel;
      e.bank = bank;
      mq.push_back(e);
    end
    s1_pend = acc;
    s1_sel  = sel;
    @(negedge aclk);
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready_a", req_ready_a, 0);
    chk("rst_rden_a",      rden_a, 0);
    chk("rst_rsp_valid_a", rsp_valid_a, 0);
    chk("rst_rsp_data_a",  rsp_data_a, 0);
    chk("rst_rsp_col_a",   rsp_col_a, 0);
    chk("rst_ccnt_a",      ccnt_a, 0);
    chk("rst_req_ready_b", req_ready_b, 0);
    chk("rst_rsp_valid_b", rsp_valid_b, 0);
    chk("rst_rsp_data_b",  rsp_data_b, 0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    acc_cnt     = 0;
    aresetn     = 1'b0;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    req_addr    = 8'h00;
    bank_select = 2'b00;
    bank_rd     = '0;
    model_reset();
    #1;
    check_reset_values();
    @(negedge aclk);
    aresetn = 1'b1;

    // single read: bank 1 data one cycle after accept, response two cycles after
    cycle(1'b1, 1'b1, 2'b01, 8'h12, rnd_bank());
    cycle(1'b0, 1'b1, 2'b00, 8'h00, {32'h0, 32'hDEADBEEF, 32'h0});
    #1;
    chk("single_valid", rsp_valid_a, 1);
    chk("single_data",  rsp_data_a, 32'hDEADBEEF);
    chk("single_col",   rsp_col_a, 0);
    cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());
    cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // streaming, alternating selects
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 2'(i % 2), 8'(i), rnd_bank());
    end
    repeat (3) cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // backpressure: only three accepts, then drain
    acc_cnt = 0;
    repeat (6) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), rnd_bank());
    chk("bp_accepts", acc_cnt, 3);
    repeat (4) cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());
    cycle(1'b1, 1'b1, 2'b00, 8'h00, rnd_bank());
    repeat (3) cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // collision flag: bank 0 data tagged as colliding
    cycle(1'b1, 1'b1, 2'b10, 8'h40, rnd_bank());
    cycle(1'b0, 1'b0, 2'b00, 8'h00, {64'h0, 32'hC0FFEE00});
    #1;
    chk("coll_data", rsp_data_a, 32'hC0FFEE00);
    chk("coll_flag", rsp_col_a, 1);
    cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());
    cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // select 3 on the three-bank instance names no bank
    cycle(1'b1, 1'b1, 2'b11, 8'h55, rnd_bank());
    cycle(1'b0, 1'b1, 2'b00, 8'h00, {$urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1});
    #1;
    chk("oor_valid_b", rsp_valid_b, 1);
    chk("oor_data_b",  rsp_data_b, 0);
    cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // reset with two entries in the FIFO and one in stage 1
    repeat (3) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), rnd_bank());
    req_valid = 1'b0;
    aresetn   = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, 2'($urandom_range(0, 3)),
            8'($urandom), rnd_bank());
    end
    repeat (5) cycle(1'b0, 1'b1, 2'b00, 8'h00, rnd_bank());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
